piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port data_in  input  WIDTH  parallel word to serialize.
REQ-005 SHALL have port load_valid  input  1  word on data_in is offered.
REQ-006 SHALL have port msb_first  input  1  bit order for the offered word: 1 = MSB first, 0 = LSB first.
REQ-007 SHALL have port load_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port serial_out  output  1  serial data bit.
REQ-009 SHALL have port frame  output  1  high while serial_out carries a valid data bit.
REQ-010 SHALL have port done  output  1  one-cycle strobe marking the last bit of a word.

Function
REQ-011 SHALL implement two states, IDLE and SHIFT, plus a WIDTH-bit shift register, a bit counter of clog2(WIDTH) bits, and a latched order flag.
REQ-012 SHALL accept a word at a posedge where load_valid=1 and load_ready=1; data_in and msb_first are captured only at that edge.
REQ-013 SHALL drive load_ready = 1 in IDLE, and in SHIFT only during the last-bit cycle (counter = WIDTH-1); otherwise 0.
REQ-014 SHALL drive the first bit of an accepted word on serial_out in the cycle after acceptance, with frame=1 (latency 1 cycle).
REQ-015 SHALL present exactly WIDTH bits on consecutive cycles, one bit per cycle, in the captured order.
REQ-016 SHALL assert done=1 only in the cycle presenting bit WIDTH-1 of a word.
REQ-017 SHALL, on acceptance during the last-bit cycle, present the new word's first bit in the next cycle, with no gap and frame held at 1 (back-to-back streaming).
REQ-018 SHALL return to IDLE after the last bit when no word is accepted; in IDLE, serial_out=0, frame=0 and done=0.
REQ-019 SHALL ignore load_valid whenever load_ready=0; an in-flight word SHALL NOT be corrupted by changes on data_in or msb_first.
REQ-020 SHALL drive serial_out, frame and done from registers (no combinational path from inputs); load_ready MAY be combinational from state and counter only.
REQ-021 SHALL wrap the bit counter from WIDTH-1 to 0 on each word boundary.

Reset
REQ-022 SHALL, while rst=1, force state=IDLE, shift register=0, counter=0, serial_out=0, frame=0, done=0 and load_ready=0, asynchronously and independent of clk.
REQ-023 SHALL abort a word in progress when rst asserts mid-word; no remaining bits are sent after release.
REQ-024 SHALL assert load_ready=1 in the first cycle after rst deasserts; no word is accepted on an edge where rst=1.

Verification (WIDTH=8)
REQ-025 SHALL pass this scenario: load 0xC1 with msb_first=1 -> serial_out 1,1,0,0,0,0,0,1 on cycles 1..8 after acceptance; frame=1 throughout; done=1 on cycle 8 only.
REQ-026 SHALL pass this scenario: load 0xC1 with msb_first=0 -> serial_out 1,0,0,0,0,0,1,1; then IDLE with serial_out=0 and frame=0.
REQ-027 SHALL pass this scenario: load 0xF0 (MSB first), then hold load_valid with 0x0F during the last-bit cycle -> 16 contiguous bits 11110000 00001111; frame never drops; done pulses on bits 8 and 16.
REQ-028 SHALL pass this scenario: hold load_valid=1 with 0xFF while 0xAA is shifting -> 0xFF is not accepted before the last-bit cycle, and 0xAA is output intact.
REQ-029 SHALL pass this scenario: assert rst asynchronously after bit 3 of 0xAA -> outputs go to 0 immediately, without waiting for a clock edge; after release, load_ready=1 and no residual bits are sent.
REQ-030 SHALL pass this scenario: change data_in from 0xC1 to 0x3E one cycle after accepting 0xC1 -> output is still 0xC1's bit sequence.

Source files
------------

// File: rtl/piso_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// piso_tx_if : parallel-load / serial-out handshake bundle for piso_tx
// Revision   : 1.0
// ---------------------------------------------------------------------------
interface piso_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             msb_first;
  logic             load_ready;
  logic             serial_out;
  logic             frame;
  logic             done;

  modport master (
    output data_in,
    output load_valid,
    output msb_first,
    input  load_ready,
    input  serial_out,
    input  frame,
    input  done
  );

  modport slave (
    input  data_in,
    input  load_valid,
    input  msb_first,
    output load_ready,
    output serial_out,
    output frame,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// piso_tx  : parallel-in serial-out transmitter, selectable bit order,
//            back-to-back word streaming on the last-bit cycle
// Revision : 1.0
// ---------------------------------------------------------------------------
module piso_tx #(
  parameter int WIDTH = 8
) (
  input  wire logic clk,
  input  wire logic rst,
  piso_tx_if.slave  bus
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  PENULT   = CNT_W'(WIDTH - 2);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             order_q, order_d;
  logic             serial_out_q, serial_out_d;
  logic             frame_q, frame_d;
  logic             done_q,  done_d;

  logic             load_ready;
  logic             accept;
  logic             last_bit;

  // rst gating keeps ready low during the asynchronous reset window
  assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  assign load_ready = !rst && ((state_q == IDLE) || last_bit);
  assign accept     = bus.load_valid && load_ready;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    order_d      = order_q;
    serial_out_d = serial_out_q;
    frame_d      = frame_q;
    done_d       = done_q;

    if (accept) begin
      // First bit leaves immediately; the register keeps only the remainder
      state_d = SHIFT;
      order_d = bus.msb_first;
      cnt_d   = '0;
      frame_d = 1'b1;
      done_d  = 1'b0;
      if (bus.msb_first) begin
        serial_out_d = bus.data_in[WIDTH-1];
        shreg_d      = {bus.data_in[WIDTH-2:0], 1'b0};
      end else begin
        serial_out_d = bus.data_in[0];
        shreg_d      = {1'b0, bus.data_in[WIDTH-1:1]};
      end
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        state_d      = IDLE;
        shreg_d      = '0;
        cnt_d        = '0;
        serial_out_d = 1'b0;
        frame_d      = 1'b0;
        done_d       = 1'b0;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        frame_d = 1'b1;
        done_d  = (cnt_q == PENULT);
        if (order_q) begin
          serial_out_d = shreg_q[WIDTH-1];
          shreg_d      = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
          serial_out_d = shreg_q[0];
          shreg_d      = {1'b0, shreg_q[WIDTH-1:1]};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      order_q      <= 1'b0;
      serial_out_q <= 1'b0;
      frame_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      order_q      <= order_d;
      serial_out_q <= serial_out_d;
      frame_q      <= frame_d;
      done_q       <= done_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.serial_out = serial_out_q;
  assign bus.frame      = frame_q;
  assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_piso_tx : directed self-checking bench for piso_tx (WIDTH = 8)
// Revision   : 1.0
// ---------------------------------------------------------------------------
module tb_piso_tx;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  piso_tx_if #(.WIDTH(8)) bif ();

  piso_tx #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic so, input logic fr, input logic dn);
    chk({tag, "_so"},    {31'd0, bif.serial_out}, {31'd0, so});
    chk({tag, "_frame"}, {31'd0, bif.frame},      {31'd0, fr});
    chk({tag, "_done"},  {31'd0, bif.done},       {31'd0, dn});
  endtask

  task automatic offer(input logic [7:0] d, input logic msb);
    bif.data_in    = d;
    bif.msb_first  = msb;
    bif.load_valid = 1'b1;
  endtask

  initial begin
    logic [15:0] seq;
    total          = 0;
    bad            = 0;
    rst            = 1'b0;
    bif.data_in    = '0;
    bif.load_valid = 1'b0;
    bif.msb_first  = 1'b0;

    // reset state, before and across a clock edge
    #2 rst = 1'b1;
    #1;
    chk_out("rst_async", 1'b0, 1'b0, 1'b0);
    chk("rst_ready", {31'd0, bif.load_ready}, 32'd0);
    offer(8'hFF, 1'b1);
    tick();
    chk_out("rst_edge", 1'b0, 1'b0, 1'b0);
    chk("rst_edge_ready", {31'd0, bif.load_ready}, 32'd0);
    bif.load_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, bif.load_ready}, 32'd1);
    chk_out("post_rst_idle", 1'b0, 1'b0, 1'b0);

    // 0xC1 MSB first
    offer(8'hC1, 1'b1);
    tick();
    bif.load_valid = 1'b0;
    seq = 16'hC100;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("c1msb_b%0d", i), seq[15-i], 1'b1, i == 7);
      chk($sformatf("c1msb_rdy%0d", i), {31'd0, bif.load_ready}, {31'd0, i == 7});
      tick();
    end
    chk_out("c1msb_idle", 1'b0, 1'b0, 1'b0);
    chk("c1msb_idle_rdy", {31'd0, bif.load_ready}, 32'd1);

    // 0xC1 LSB first
    offer(8'hC1, 1'b0);
    tick();
    bif.load_valid = 1'b0;
    seq = 16'h8300;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("c1lsb_b%0d", i), seq[15-i], 1'b1, i == 7);
      tick();
    end
    chk_out("c1lsb_idle", 1'b0, 1'b0, 1'b0);

    // back-to-back 0xF0 then 0x0F
    offer(8'hF0, 1'b1);
    tick();
    bif.load_valid = 1'b0;
    seq = 16'hF00F;
    for (int i = 0; i < 16; i++) begin
      chk_out($sformatf("b2b_b%0d", i), seq[15-i], 1'b1, (i == 7) || (i == 15));
      if (i == 7) offer(8'h0F, 1'b1);
      tick();
      if (i == 7) bif.load_valid = 1'b0;
    end
    chk_out("b2b_idle", 1'b0, 1'b0, 1'b0);

    // 0xFF held while 0xAA shifts: taken only at the last-bit cycle
    offer(8'hAA, 1'b1);
    tick();
    bif.data_in = 8'hFF;
    seq = 16'hAAFF;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("hold_rdy%0d", i), {31'd0, bif.load_ready}, {31'd0, (i == 7) || (i == 15)});
      chk_out($sformatf("hold_b%0d", i), seq[15-i], 1'b1, (i == 7) || (i == 15));
      tick();
      if (i == 7) bif.load_valid = 1'b0;
    end
    chk_out("hold_idle", 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-word while a 1 is on the line
    offer(8'hAA, 1'b1);
    tick();
    bif.load_valid = 1'b0;
    seq = 16'hAA00;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("abort_b%0d", i), seq[15-i], 1'b1, 1'b0);
      if (i < 2) tick();
    end
    #2 rst = 1'b1;
    #1;
    chk_out("abort_async", 1'b0, 1'b0, 1'b0);
    chk("abort_async_rdy", {31'd0, bif.load_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_rel_rdy", {31'd0, bif.load_ready}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_out($sformatf("abort_quiet%0d", i), 1'b0, 1'b0, 1'b0);
    end

    // inputs change right after acceptance
    offer(8'hC1, 1'b1);
    tick();
    bif.load_valid = 1'b0;
    bif.data_in    = 8'h3E;
    bif.msb_first  = 1'b0;
    seq = 16'hC100;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("stable_b%0d", i), seq[15-i], 1'b1, i == 7);
      tick();
    end
    chk_out("stable_idle", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
